// File: rtl/i2q2_engine_if.sv
// ---------------------------------------------------------------------------
// i2q2_engine_if
// Bundles the accumulation-complete handshake, the six signed early/prompt/
// late I/Q accumulations and the power results of the I^2+Q^2 engine.
//
// Signals:
//   accumulation_complete  1-cycle pulse, I/Q inputs valid in the same cycle
//   i_/q_early/prompt/late ACC_WIDTH signed accumulations
//   i2q2_valid             1-cycle strobe, result set is coherent
//   i2q2_early/prompt/late I2Q2_WIDTH unsigned power results
//   busy                   computation in progress
//   overrun                sticky: a pulse arrived while busy
//
// Modports: master (accumulator side), slave (engine side).
// ---------------------------------------------------------------------------
interface i2q2_engine_if #(
  parameter int ACC_WIDTH  = 16,
  parameter int I2Q2_WIDTH = 30
);
  logic                          accumulation_complete;
  logic signed [ACC_WIDTH-1:0]   i_early;
  logic signed [ACC_WIDTH-1:0]   q_early;
  logic signed [ACC_WIDTH-1:0]   i_prompt;
  logic signed [ACC_WIDTH-1:0]   q_prompt;
  logic signed [ACC_WIDTH-1:0]   i_late;
  logic signed [ACC_WIDTH-1:0]   q_late;
  logic                          i2q2_valid;
  logic [I2Q2_WIDTH-1:0]         i2q2_early;
  logic [I2Q2_WIDTH-1:0]         i2q2_prompt;
  logic [I2Q2_WIDTH-1:0]         i2q2_late;
  logic                          busy;
  logic                          overrun;

  modport master (
    output accumulation_complete,
    output i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    input  i2q2_valid, i2q2_early, i2q2_prompt, i2q2_late,
    input  busy, overrun
  );

  modport slave (
    input  accumulation_complete,
    input  i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    output i2q2_valid, i2q2_early, i2q2_prompt, i2q2_late,
    output busy, overrun
  );
endinterface

// File: rtl/i2q2_engine.sv
// ---------------------------------------------------------------------------
// i2q2_engine
// Power-detection stage: on each accumulation-complete pulse it captures the
// early/prompt/late I and Q accumulations and computes I^2+Q^2 for each
// subchannel with one shared squarer, time-multiplexed over six cycles
// (order I_e, Q_e, I_p, Q_p, I_l, Q_l). Results commit one per odd cycle;
// i2q2_valid pulses once the whole set is written.
//
// Ports:
//   clk           system clock
//   global_reset  synchronous, active-high reset
//   bus           i2q2_engine_if.slave (inputs, results, valid, busy, overrun)
//
// Configuration macro:
//   I2Q2_SATURATE_EN  defined   -> results clamp to 2^I2Q2_WIDTH-1
//                     undefined -> results keep the low I2Q2_WIDTH bits
// ---------------------------------------------------------------------------
module i2q2_engine #(
  parameter int ACC_WIDTH  = 16,
  parameter int I2Q2_WIDTH = 30
) (
  input  logic            clk,
  input  logic            global_reset,
  i2q2_engine_if.slave    bus
);

  localparam int SQ_W  = 2 * ACC_WIDTH;
  localparam int SUM_W = SQ_W + 1;
  // Zero-extended sum wide enough that the bits above I2Q2_WIDTH always exist
  localparam int EXT_W = SUM_W + I2Q2_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]                  r_state;
  logic [2:0]                  r_idx;
  logic signed [ACC_WIDTH-1:0] r_op [0:5];
  logic [SQ_W-1:0]             r_partial;
  logic [I2Q2_WIDTH-1:0]       r_result [0:2];
  logic                        r_valid;
  logic                        r_overrun;

  logic signed [ACC_WIDTH-1:0] w_in [0:5];
  logic signed [ACC_WIDTH-1:0] w_op;
  logic signed [SQ_W-1:0]      w_op_ext;
  logic signed [SQ_W-1:0]      w_prod;
  logic [SQ_W-1:0]             w_sq;
  logic [SUM_W-1:0]            w_sum;
  logic [EXT_W-1:0]            w_sum_ext;
  logic [I2Q2_WIDTH-1:0]       w_fit;
  logic                        w_mul;

  assign w_in[0] = bus.i_early;
  assign w_in[1] = bus.q_early;
  assign w_in[2] = bus.i_prompt;
  assign w_in[3] = bus.q_prompt;
  assign w_in[4] = bus.i_late;
  assign w_in[5] = bus.q_late;

  assign w_mul = (r_state == ST_MUL);

  // Operand select for the shared squarer
  always_comb begin
    w_op = r_op[0];
    case (r_idx)
      3'd0:    w_op = r_op[0];
      3'd1:    w_op = r_op[1];
      3'd2:    w_op = r_op[2];
      3'd3:    w_op = r_op[3];
      3'd4:    w_op = r_op[4];
      3'd5:    w_op = r_op[5];
      default: w_op = r_op[0];
    endcase
  end

  // Square of the sign-extended operand is never negative and its maximum,
  // (-2^(ACC_WIDTH-1))^2, still fits below the sign bit of SQ_W.
  assign w_op_ext  = {{ACC_WIDTH{w_op[ACC_WIDTH-1]}}, w_op};
  assign w_prod    = w_op_ext * w_op_ext;
  assign w_sq      = $unsigned(w_prod);
  assign w_sum     = {1'b0, r_partial} + {1'b0, w_sq};
  assign w_sum_ext = {{I2Q2_WIDTH{1'b0}}, w_sum};

`ifdef I2Q2_SATURATE_EN
  logic w_over;
  assign w_over = |w_sum_ext[EXT_W-1:I2Q2_WIDTH];
  assign w_fit  = w_over ? {I2Q2_WIDTH{1'b1}} : w_sum_ext[I2Q2_WIDTH-1:0];
`else
  // Upper bits are deliberately discarded in wrap mode
  logic w_unused_hi;
  assign w_unused_hi = |w_sum_ext[EXT_W-1:I2Q2_WIDTH];
  assign w_fit       = w_sum_ext[I2Q2_WIDTH-1:0];
`endif

  // Control, operand capture and partial sum
  always_ff @(posedge clk) begin
    if (global_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_partial <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        r_op[k] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.accumulation_complete) begin
            for (int k = 0; k < 6; k++) begin
              r_op[k] <= w_in[k];
            end
            r_idx   <= 3'd0;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // A pulse while busy, including the final MUL cycle, is dropped
          if (bus.accumulation_complete) begin
            r_overrun <= 1'b1;
          end
          if (!r_idx[0]) begin
            r_partial <= w_sq;
          end
          if (r_idx == 3'd5) begin
            r_valid <= 1'b1;
            r_idx   <= 3'd0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

  // One result register per subchannel, written on its odd MUL cycle
  for (genvar gi = 0; gi < 3; gi++) begin : g_result
    localparam logic [2:0] WR_IDX = 3'(2 * gi + 1);
    always_ff @(posedge clk) begin
      if (global_reset) begin
        r_result[gi] <= '0;
      end else if (w_mul && (r_idx == WR_IDX)) begin
        r_result[gi] <= w_fit;
      end
    end
  end

  assign bus.i2q2_valid  = r_valid;
  assign bus.i2q2_early  = r_result[0];
  assign bus.i2q2_prompt = r_result[1];
  assign bus.i2q2_late   = r_result[2];
  assign bus.busy        = w_mul;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_i2q2_engine.sv
// ---------------------------------------------------------------------------
// tb_i2q2_engine
// Directed testbench for i2q2_engine with hand-computed expected values.
// Honours I2Q2_SATURATE_EN for the overflow expectations.
// ---------------------------------------------------------------------------
module tb_i2q2_engine;

  localparam int AW = 16;
  localparam int RW = 30;

`ifdef I2Q2_SATURATE_EN
  localparam logic [31:0] OVF = 32'h3FFF_FFFF;
`else
  localparam logic [31:0] OVF = 32'h0;
`endif

  logic clk;
  logic global_reset;
  int   n_checks;
  int   n_errors;

  i2q2_engine_if #(.ACC_WIDTH(AW), .I2Q2_WIDTH(RW)) bus ();

  i2q2_engine #(.ACC_WIDTH(AW), .I2Q2_WIDTH(RW)) dut (
    .clk          (clk),
    .global_reset (global_reset),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and sample 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input int ie, input int qe, input int ip,
                            input int qp, input int il, input int ql);
    bus.i_early  = AW'(ie);
    bus.q_early  = AW'(qe);
    bus.i_prompt = AW'(ip);
    bus.q_prompt = AW'(qp);
    bus.i_late   = AW'(il);
    bus.q_late   = AW'(ql);
  endtask

  // Pulse sampled at the next edge (edge k); returns 1 ns after edge k
  task automatic pulse();
    bus.accumulation_complete = 1'b1;
    tick();
    bus.accumulation_complete = 1'b0;
  endtask

  task automatic do_reset();
    global_reset = 1'b1;
    tick();
    tick();
    global_reset = 1'b0;
  endtask

  // Full single computation with cycle-by-cycle timing checks
  task automatic run_single(input string tag,
                            input int ie, input int qe, input int ip,
                            input int qp, input int il, input int ql,
                            input logic [31:0] e_exp, input logic [31:0] p_exp,
                            input logic [31:0] l_exp);
    int busy_cnt;
    int early_upd_ok;
    logic [31:0] early_before;
    early_before = 32'(bus.i2q2_early);
    set_inputs(ie, qe, ip, qp, il, ql);
    pulse();
    busy_cnt = bus.busy ? 1 : 0;
    early_upd_ok = 1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n < 6 && bus.busy) busy_cnt++;
      if (n < 6 && bus.i2q2_valid) check({tag, "_early_valid"}, 32'(bus.i2q2_valid), 32'd0);
      if (n == 1 && 32'(bus.i2q2_early) !== early_before) early_upd_ok = 0;
      if (n == 2 && 32'(bus.i2q2_early) !== e_exp) early_upd_ok = 0;
    end
    check({tag, "_valid_k6"}, 32'(bus.i2q2_valid), 32'd1);
    check({tag, "_busy_low_k6"}, 32'(bus.busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
    check({tag, "_early_at_k2"}, 32'(early_upd_ok), 32'd1);
    check({tag, "_early"}, 32'(bus.i2q2_early), e_exp);
    check({tag, "_prompt"}, 32'(bus.i2q2_prompt), p_exp);
    check({tag, "_late"}, 32'(bus.i2q2_late), l_exp);
    tick();
    check({tag, "_valid_k7"}, 32'(bus.i2q2_valid), 32'd0);
    $display("txn %s early=%0d prompt=%0d late=%0d", tag,
             bus.i2q2_early, bus.i2q2_prompt, bus.i2q2_late);
  endtask

  initial begin
    int saw_valid;
    n_checks = 0;
    n_errors = 0;
    global_reset = 1'b1;
    bus.accumulation_complete = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);

    // Reset and idle
    do_reset();
    saw_valid = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.i2q2_valid) saw_valid = 1;
    end
    check("rst_valid_never", 32'(saw_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_early", 32'(bus.i2q2_early), 32'd0);
    check("rst_prompt", 32'(bus.i2q2_prompt), 32'd0);
    check("rst_late", 32'(bus.i2q2_late), 32'd0);
    $display("txn reset idle done");

    // Basic vector
    run_single("basic", 3, -4, 0, 0, -100, 100, 32'd25, 32'd0, 32'd20000);
    check("basic_overrun", 32'(bus.overrun), 32'd0);

    // Full-scale: 2^31 overflows, 2^30 overflows, small value stays exact
    run_single("fs_all", -32768, -32768, -32768, -32768, -32768, -32768, OVF, OVF, OVF);
    run_single("fs_mix", -32768, 0, 1, 1, -32768, -32768, OVF, 32'd2, OVF);
    run_single("near_fs", 32767, 0, -32767, 0, 0, -32767,
               32'd1073676289, 32'd1073676289, 32'd1073676289);

    // Overrun: second pulse at k+3 is dropped
    set_inputs(5, 12, 7, -24, -1, -1);
    pulse();
    tick();
    tick();
    set_inputs(100, 100, 100, 100, 100, 100);
    pulse();
    check("ovr_flag_k3", 32'(bus.overrun), 32'd1);
    check("ovr_busy_k3", 32'(bus.busy), 32'd1);
    tick();
    tick();
    tick();
    check("ovr_valid_k6", 32'(bus.i2q2_valid), 32'd1);
    check("ovr_early", 32'(bus.i2q2_early), 32'd169);
    check("ovr_prompt", 32'(bus.i2q2_prompt), 32'd625);
    check("ovr_late", 32'(bus.i2q2_late), 32'd2);
    for (int n = 0; n < 8; n++) tick();
    check("ovr_sticky", 32'(bus.overrun), 32'd1);
    check("ovr_no_restart", 32'(bus.busy), 32'd0);
    $display("txn overrun early=%0d prompt=%0d late=%0d ovr=%0d",
             bus.i2q2_early, bus.i2q2_prompt, bus.i2q2_late, bus.overrun);
    do_reset();
    check("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Back-to-back pulses at k and k+7
    set_inputs(1, 2, 3, 4, 5, 6);
    pulse();
    for (int n = 1; n <= 6; n++) tick();
    check("b2b_valid1", 32'(bus.i2q2_valid), 32'd1);
    check("b2b_early1", 32'(bus.i2q2_early), 32'd5);
    check("b2b_prompt1", 32'(bus.i2q2_prompt), 32'd25);
    check("b2b_late1", 32'(bus.i2q2_late), 32'd61);
    set_inputs(-10, 10, 20, 0, 0, -30);
    pulse();
    check("b2b_busy_k7", 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 6; n++) tick();
    check("b2b_valid2", 32'(bus.i2q2_valid), 32'd1);
    check("b2b_early2", 32'(bus.i2q2_early), 32'd200);
    check("b2b_prompt2", 32'(bus.i2q2_prompt), 32'd400);
    check("b2b_late2", 32'(bus.i2q2_late), 32'd900);
    check("b2b_overrun", 32'(bus.overrun), 32'd0);
    $display("txn back_to_back early=%0d prompt=%0d late=%0d",
             bus.i2q2_early, bus.i2q2_prompt, bus.i2q2_late);

    // Pulse coinciding with the final MUL edge is dropped
    tick();
    set_inputs(2, 2, 2, 2, 2, 2);
    pulse();
    for (int n = 1; n <= 5; n++) tick();
    set_inputs(9, 9, 9, 9, 9, 9);
    pulse();
    check("edge5_valid", 32'(bus.i2q2_valid), 32'd1);
    check("edge5_overrun", 32'(bus.overrun), 32'd1);
    tick();
    check("edge5_not_captured", 32'(bus.busy), 32'd0);
    check("edge5_early", 32'(bus.i2q2_early), 32'd8);
    $display("txn drop_at_last_edge ovr=%0d busy=%0d", bus.overrun, bus.busy);
    do_reset();

    // Reset mid-computation at k+3, new pulse at k+5
    set_inputs(6, 8, 1, 0, 0, 1);
    pulse();
    tick();
    tick();
    check("abort_early_pre", 32'(bus.i2q2_early), 32'd100);
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_early_clr", 32'(bus.i2q2_early), 32'd0);
    saw_valid = 0;
    tick();
    if (bus.i2q2_valid) saw_valid = 1;
    set_inputs(-3, 3, 4, 4, -7, 0);
    pulse();
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n < 6 && bus.i2q2_valid) saw_valid = 1;
    end
    check("abort_no_stray_valid", 32'(saw_valid), 32'd0);
    check("abort_valid_k11", 32'(bus.i2q2_valid), 32'd1);
    check("abort_early", 32'(bus.i2q2_early), 32'd18);
    check("abort_prompt", 32'(bus.i2q2_prompt), 32'd32);
    check("abort_late", 32'(bus.i2q2_late), 32'd49);
    $display("txn abort_restart early=%0d prompt=%0d late=%0d",
             bus.i2q2_early, bus.i2q2_prompt, bus.i2q2_late);

    // Reset together with a pulse: nothing captured
    global_reset = 1'b1;
    bus.accumulation_complete = 1'b1;
    tick();
    global_reset = 1'b0;
    bus.accumulation_complete = 1'b0;
    check("rst_with_pulse_busy", 32'(bus.busy), 32'd0);
    $display("txn reset_with_pulse busy=%0d", bus.busy);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
